// File: rtl/wishbone_fifo_port.sv
// Wishbone slave that queues words written to a data port into a small FIFO
// and presents them to user logic as a valid/ready stream.
`timescale 1ns/1ps

module wishbone_fifo_port #(
    parameter logic [31:0] DATA_ADDR   = 32'h30000010,
    parameter logic [31:0] STATUS_ADDR = 32'h30000014,
    parameter int          DEPTH       = 8,
    parameter int          PTR_W       = 3
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [31:0] wbs_dat_i,
    input  logic [31:0] wbs_adr_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic [31:0] out_data_o,
    output logic        out_valid_o,
    input  logic        out_ready_i
);

    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

    logic [31:0]      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W:0]   count_reg;
    logic [PTR_W:0]   count_next;
    logic             overflow_reg;
    logic             overflow_next;
    logic [7:0]       drop_cnt_reg;
    logic [7:0]       drop_cnt_next;
    logic             ack_reg;
    logic [31:0]      dat_reg;
    logic [31:0]      dat_next;

    logic        hit_data;
    logic        hit_status;
    logic        req;
    logic        empty;
    logic        full;
    logic        pop;
    logic        push;
    logic        drop;
    logic        clear;
    logic [31:0] status_word;

    always_comb begin
        hit_data    = (wbs_adr_i == DATA_ADDR);
        hit_status  = (wbs_adr_i == STATUS_ADDR);
        req         = wbs_cyc_i & wbs_stb_i & ~ack_reg & (hit_data | hit_status);
        empty       = (count_reg == '0);
        full        = (count_reg == FULL_COUNT);
        pop         = ~empty & out_ready_i;
        // A full FIFO still accepts a word when the head leaves at the same edge.
        push        = req & wbs_we_i & hit_data & (~full | pop);
        drop        = req & wbs_we_i & hit_data & full & ~pop;
        clear       = req & wbs_we_i & hit_status & wbs_dat_i[0];
        status_word = {drop_cnt_reg, 5'b0, overflow_reg, full, empty, 16'(count_reg)};

        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase

        overflow_next = overflow_reg;
        drop_cnt_next = drop_cnt_reg;
        if (drop) begin
            overflow_next = 1'b1;
            if (drop_cnt_reg != 8'hFF)
                drop_cnt_next = drop_cnt_reg + 1'b1;
        end
        if (clear) begin
            overflow_next = 1'b0;
            drop_cnt_next = 8'h00;
        end

        dat_next = dat_reg;
        if (req & ~wbs_we_i) begin
            if (hit_data)
                dat_next = empty ? 32'h0 : mem[rd_ptr_reg];
            else
                dat_next = status_word;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
            drop_cnt_reg <= 8'h00;
            ack_reg      <= 1'b0;
            dat_reg      <= 32'h0;
        end else begin
            if (push)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            count_reg    <= count_next;
            overflow_reg <= overflow_next;
            drop_cnt_reg <= drop_cnt_next;
            ack_reg      <= req;
            dat_reg      <= dat_next;
        end
    end

    // Storage carries no reset; only the pointers define which words are live.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i && push)
            mem[wr_ptr_reg] <= wbs_dat_i;
    end

    assign wbs_ack_o   = ack_reg;
    assign wbs_dat_o   = dat_reg;
    assign out_valid_o = ~empty;
    assign out_data_o  = mem[rd_ptr_reg];

endmodule

// File: tb/tb_wishbone_fifo_port.sv
// Directed bench for wishbone_fifo_port: bus handshake, FIFO fill/overflow,
// status/control port, streaming order and mid-stream reset.
`timescale 1ns/1ps

module tb_wishbone_fifo_port;

    localparam logic [31:0] DATA_ADDR   = 32'h30000010;
    localparam logic [31:0] STATUS_ADDR = 32'h30000014;
    localparam logic [31:0] BAD_ADDR    = 32'h30000018;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i = 1'b1;
    logic        wbs_stb_i = 1'b0;
    logic        wbs_cyc_i = 1'b0;
    logic        wbs_we_i = 1'b0;
    logic [31:0] wbs_dat_i = '0;
    logic [31:0] wbs_adr_i = '0;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic [31:0] out_data_o;
    logic        out_valid_o;
    logic        out_ready_i = 1'b0;

    int vec_cnt = 0;
    int err_cnt = 0;

    wishbone_fifo_port #(
        .DATA_ADDR  (DATA_ADDR),
        .STATUS_ADDR(STATUS_ADDR),
        .DEPTH      (8),
        .PTR_W      (3)
    ) dut (
        .wb_clk_i   (wb_clk_i),
        .wb_rst_i   (wb_rst_i),
        .wbs_stb_i  (wbs_stb_i),
        .wbs_cyc_i  (wbs_cyc_i),
        .wbs_we_i   (wbs_we_i),
        .wbs_dat_i  (wbs_dat_i),
        .wbs_adr_i  (wbs_adr_i),
        .wbs_ack_o  (wbs_ack_o),
        .wbs_dat_o  (wbs_dat_o),
        .out_data_o (out_data_o),
        .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    // One bus transfer; lat = cycles from request to ack (0 = never acked).
    task automatic wb_xfer(input logic [31:0] adr, input logic we, input logic [31:0] wdat,
                           output int lat, output logic [31:0] rdat, output logic ack_after);
        logic got;
        got = 1'b0;
        lat = 0;
        rdat = '0;
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
        wbs_adr_i = adr;  wbs_dat_i = wdat;
        for (int i = 1; i <= 4; i++) begin
            if (!got) begin
                @(posedge wb_clk_i); #1;
                if (wbs_ack_o) begin
                    got = 1'b1;
                    lat = i;
                    rdat = wbs_dat_o;
                end
            end
        end
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
        @(posedge wb_clk_i); #1;
        ack_after = wbs_ack_o;
        $display("wb %s adr=%h wdat=%h rdat=%h lat=%0d", we ? "WR" : "RD", adr, wdat, rdat, lat);
    endtask

    task automatic test_reset;
        int lat; logic [31:0] rd; logic aa;
        repeat (3) @(posedge wb_clk_i);
        #1 wb_rst_i = 1'b0;
        vec_cnt++; if (wbs_ack_o !== 1'b0) begin err_cnt++; $display("FAIL reset_ack got=%b exp=0", wbs_ack_o); end
        vec_cnt++; if (wbs_dat_o !== 32'h0) begin err_cnt++; $display("FAIL reset_dat got=%h exp=00000000", wbs_dat_o); end
        vec_cnt++; if (out_valid_o !== 1'b0) begin err_cnt++; $display("FAIL reset_valid got=%b exp=0", out_valid_o); end
        wb_xfer(STATUS_ADDR, 1'b0, 32'h0, lat, rd, aa);
        vec_cnt++; if (lat !== 1) begin err_cnt++; $display("FAIL reset_stat_lat got=%0d exp=1", lat); end
        vec_cnt++; if (rd !== 32'h00010000) begin err_cnt++; $display("FAIL reset_stat got=%h exp=00010000", rd); end
        vec_cnt++; if (aa !== 1'b0) begin err_cnt++; $display("FAIL reset_ack_clear got=%b exp=0", aa); end
    endtask

    task automatic test_single_push;
        int lat; logic [31:0] rd; logic aa;
        out_ready_i = 1'b0;
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1;
        wbs_adr_i = DATA_ADDR; wbs_dat_i = 32'hA5A50001;
        @(posedge wb_clk_i); #1;
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
        $display("wb WR adr=%h wdat=A5A50001 ack=%b", DATA_ADDR, wbs_ack_o);
        vec_cnt++; if (wbs_ack_o !== 1'b1) begin err_cnt++; $display("FAIL push_ack got=%b exp=1", wbs_ack_o); end
        vec_cnt++; if (out_valid_o !== 1'b1) begin err_cnt++; $display("FAIL push_valid got=%b exp=1", out_valid_o); end
        vec_cnt++; if (out_data_o !== 32'hA5A50001) begin err_cnt++; $display("FAIL push_data got=%h exp=A5A50001", out_data_o); end
        @(posedge wb_clk_i); #1;
        vec_cnt++; if (wbs_ack_o !== 1'b0) begin err_cnt++; $display("FAIL push_ack_pulse got=%b exp=0", wbs_ack_o); end
        wb_xfer(STATUS_ADDR, 1'b0, 32'h0, lat, rd, aa);
        vec_cnt++; if (rd !== 32'h00000001) begin err_cnt++; $display("FAIL push_stat got=%h exp=00000001", rd); end
        wb_xfer(DATA_ADDR, 1'b0, 32'h0, lat, rd, aa);
        vec_cnt++; if (rd !== 32'hA5A50001) begin err_cnt++; $display("FAIL push_peek got=%h exp=A5A50001", rd); end
        vec_cnt++; if (out_valid_o !== 1'b1) begin err_cnt++; $display("FAIL peek_no_pop got=%b exp=1", out_valid_o); end
        out_ready_i = 1'b1;
        @(posedge wb_clk_i); #1;
        out_ready_i = 1'b0;
        vec_cnt++; if (out_valid_o !== 1'b0) begin err_cnt++; $display("FAIL push_drain got=%b exp=0", out_valid_o); end
    endtask

    task automatic test_back_to_back;
        int lat; logic [31:0] rd; logic aa;
        out_ready_i = 1'b0;
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1;
        wbs_adr_i = DATA_ADDR; wbs_dat_i = 32'h00000011;
        @(posedge wb_clk_i); #1;
        vec_cnt++; if (wbs_ack_o !== 1'b1) begin err_cnt++; $display("FAIL b2b_ack0 got=%b exp=1", wbs_ack_o); end
        wbs_dat_i = 32'h00000022;
        @(posedge wb_clk_i); #1;
        vec_cnt++; if (wbs_ack_o !== 1'b0) begin err_cnt++; $display("FAIL b2b_ack1 got=%b exp=0", wbs_ack_o); end
        @(posedge wb_clk_i); #1;
        vec_cnt++; if (wbs_ack_o !== 1'b1) begin err_cnt++; $display("FAIL b2b_ack2 got=%b exp=1", wbs_ack_o); end
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
        $display("wb WR b2b 00000011,00000022");
        @(posedge wb_clk_i); #1;
        wb_xfer(STATUS_ADDR, 1'b0, 32'h0, lat, rd, aa);
        vec_cnt++; if (rd !== 32'h00000002) begin err_cnt++; $display("FAIL b2b_stat got=%h exp=00000002", rd); end
        vec_cnt++; if (out_data_o !== 32'h11) begin err_cnt++; $display("FAIL b2b_head0 got=%h exp=00000011", out_data_o); end
        out_ready_i = 1'b1;
        @(posedge wb_clk_i); #1;
        vec_cnt++; if (out_data_o !== 32'h22) begin err_cnt++; $display("FAIL b2b_head1 got=%h exp=00000022", out_data_o); end
        @(posedge wb_clk_i); #1;
        out_ready_i = 1'b0;
        vec_cnt++; if (out_valid_o !== 1'b0) begin err_cnt++; $display("FAIL b2b_empty got=%b exp=0", out_valid_o); end
    endtask

    task automatic test_overflow;
        int lat; logic [31:0] rd; logic aa;
        int acks;
        acks = 0;
        out_ready_i = 1'b0;
        for (int w = 1; w <= 10; w++) begin
            wb_xfer(DATA_ADDR, 1'b1, 32'(w), lat, rd, aa);
            if (lat == 1) acks++;
        end
        vec_cnt++; if (acks !== 10) begin err_cnt++; $display("FAIL ovf_acks got=%0d exp=10", acks); end
        wb_xfer(STATUS_ADDR, 1'b0, 32'h0, lat, rd, aa);
        vec_cnt++; if (rd !== 32'h02060008) begin err_cnt++; $display("FAIL ovf_stat got=%h exp=02060008", rd); end
        wb_xfer(DATA_ADDR, 1'b0, 32'h0, lat, rd, aa);
        vec_cnt++; if (rd !== 32'h00000001) begin err_cnt++; $display("FAIL ovf_peek got=%h exp=00000001", rd); end
    endtask

    task automatic test_clear;
        int lat; logic [31:0] rd; logic aa;
        wb_xfer(STATUS_ADDR, 1'b1, 32'hFFFFFFFE, lat, rd, aa);
        wb_xfer(STATUS_ADDR, 1'b0, 32'h0, lat, rd, aa);
        vec_cnt++; if (rd !== 32'h02060008) begin err_cnt++; $display("FAIL clr_bit0_zero got=%h exp=02060008", rd); end
        wb_xfer(STATUS_ADDR, 1'b1, 32'h00000001, lat, rd, aa);
        vec_cnt++; if (lat !== 1) begin err_cnt++; $display("FAIL clr_lat got=%0d exp=1", lat); end
        wb_xfer(STATUS_ADDR, 1'b0, 32'h0, lat, rd, aa);
        vec_cnt++; if (rd !== 32'h00020008) begin err_cnt++; $display("FAIL clr_stat got=%h exp=00020008", rd); end
        wb_xfer(BAD_ADDR, 1'b0, 32'h0, lat, rd, aa);
        vec_cnt++; if (lat !== 0) begin err_cnt++; $display("FAIL bad_rd_ack got=%0d exp=0", lat); end
        vec_cnt++; if (wbs_dat_o !== 32'h00020008) begin err_cnt++; $display("FAIL bad_rd_hold got=%h exp=00020008", wbs_dat_o); end
        wb_xfer(BAD_ADDR, 1'b1, 32'hDEADBEEF, lat, rd, aa);
        vec_cnt++; if (lat !== 0) begin err_cnt++; $display("FAIL bad_wr_ack got=%0d exp=0", lat); end
        wb_xfer(STATUS_ADDR, 1'b0, 32'h0, lat, rd, aa);
        vec_cnt++; if (rd !== 32'h00020008) begin err_cnt++; $display("FAIL bad_untouched got=%h exp=00020008", rd); end
    endtask

    task automatic test_drain;
        int lat; logic [31:0] rd; logic aa;
        out_ready_i = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            vec_cnt++;
            if (out_valid_o !== 1'b1 || out_data_o !== 32'(i)) begin
                err_cnt++;
                $display("FAIL drain_%0d got=%b/%h exp=1/%h", i, out_valid_o, out_data_o, 32'(i));
            end
            @(posedge wb_clk_i); #1;
        end
        out_ready_i = 1'b0;
        vec_cnt++; if (out_valid_o !== 1'b0) begin err_cnt++; $display("FAIL drain_empty got=%b exp=0", out_valid_o); end
        wb_xfer(STATUS_ADDR, 1'b0, 32'h0, lat, rd, aa);
        vec_cnt++; if (rd !== 32'h00010000) begin err_cnt++; $display("FAIL drain_stat got=%h exp=00010000", rd); end
        wb_xfer(DATA_ADDR, 1'b0, 32'h0, lat, rd, aa);
        vec_cnt++; if (rd !== 32'h0) begin err_cnt++; $display("FAIL empty_peek got=%h exp=00000000", rd); end
    endtask

    task automatic test_full_pop;
        int lat; logic [31:0] rd; logic aa;
        out_ready_i = 1'b0;
        for (int w = 1; w <= 8; w++) wb_xfer(DATA_ADDR, 1'b1, 32'(w), lat, rd, aa);
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1;
        wbs_adr_i = DATA_ADDR; wbs_dat_i = 32'h9;
        out_ready_i = 1'b1;
        @(posedge wb_clk_i); #1;
        out_ready_i = 1'b0;
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
        $display("wb WR adr=%h wdat=00000009 with pop ack=%b", DATA_ADDR, wbs_ack_o);
        vec_cnt++; if (wbs_ack_o !== 1'b1) begin err_cnt++; $display("FAIL fullpop_ack got=%b exp=1", wbs_ack_o); end
        vec_cnt++; if (out_data_o !== 32'h2) begin err_cnt++; $display("FAIL fullpop_head got=%h exp=00000002", out_data_o); end
        @(posedge wb_clk_i); #1;
        wb_xfer(STATUS_ADDR, 1'b0, 32'h0, lat, rd, aa);
        vec_cnt++; if (rd !== 32'h00020008) begin err_cnt++; $display("FAIL fullpop_stat got=%h exp=00020008", rd); end
        out_ready_i = 1'b1;
        for (int i = 2; i <= 9; i++) begin
            vec_cnt++;
            if (out_valid_o !== 1'b1 || out_data_o !== 32'(i)) begin
                err_cnt++;
                $display("FAIL fullpop_drain_%0d got=%b/%h exp=1/%h", i, out_valid_o, out_data_o, 32'(i));
            end
            @(posedge wb_clk_i); #1;
        end
        out_ready_i = 1'b0;
        vec_cnt++; if (out_valid_o !== 1'b0) begin err_cnt++; $display("FAIL fullpop_empty got=%b exp=0", out_valid_o); end
    endtask

    task automatic test_reset_mid;
        int lat; logic [31:0] rd; logic aa;
        out_ready_i = 1'b0;
        for (int w = 0; w < 5; w++) wb_xfer(DATA_ADDR, 1'b1, 32'h50 + 32'(w), lat, rd, aa);
        wb_xfer(STATUS_ADDR, 1'b0, 32'h0, lat, rd, aa);
        vec_cnt++; if (rd !== 32'h00000005) begin err_cnt++; $display("FAIL mid_stat5 got=%h exp=00000005", rd); end
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = STATUS_ADDR;
        wb_rst_i = 1'b1;
        @(posedge wb_clk_i); #1;
        wb_rst_i = 1'b0;
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        $display("wb RD adr=%h under reset ack=%b", STATUS_ADDR, wbs_ack_o);
        vec_cnt++; if (wbs_ack_o !== 1'b0) begin err_cnt++; $display("FAIL mid_ack got=%b exp=0", wbs_ack_o); end
        vec_cnt++; if (out_valid_o !== 1'b0) begin err_cnt++; $display("FAIL mid_valid got=%b exp=0", out_valid_o); end
        @(posedge wb_clk_i); #1;
        vec_cnt++; if (wbs_ack_o !== 1'b0) begin err_cnt++; $display("FAIL mid_ack_late got=%b exp=0", wbs_ack_o); end
        wb_xfer(STATUS_ADDR, 1'b0, 32'h0, lat, rd, aa);
        vec_cnt++; if (rd !== 32'h00010000) begin err_cnt++; $display("FAIL mid_stat got=%h exp=00010000", rd); end
    endtask

    initial begin
        test_reset;
        test_single_push;
        test_back_to_back;
        test_overflow;
        test_clear;
        test_drain;
        test_full_pop;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout vectors=%0d", vec_cnt);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/wishbone_fifo_port.md
Name: wishbone_fifo_port

Overview:
Wishbone slave that buffers 32-bit words written by the management core into a small FIFO. It presents them to user-project logic as a valid/ready stream, replacing single-word register handoff with a queued command path. It decodes two word addresses in the user area: a data port (push) and a status/control port. It sits between the Caravel Wishbone bus and downstream user logic that consumes commands at its own pace.

Parameters:
DATA_ADDR, 32'h30000010, full byte address of the data port; write pushes, read peeks head
STATUS_ADDR, 32'h30000014, full byte address of the status/control port
DEPTH, 8, FIFO depth in words; power of two, 2..256
PTR_W, 3, log2(DEPTH)

Ports:
wb_clk_i  input  1  single clock for all logic
wb_rst_i  input  1  reset, synchronous, active-high
wbs_stb_i  input  1  Wishbone strobe
wbs_cyc_i  input  1  Wishbone cycle
wbs_we_i  input  1  1 = write, 0 = read
wbs_dat_i  input  32  write data
wbs_adr_i  input  32  byte address; full 32-bit compare
wbs_ack_o  output  1  acknowledge, registered
wbs_dat_o  output  32  read data, registered
out_data_o  output  32  head-of-FIFO word
out_valid_o  output  1  FIFO non-empty
out_ready_i  input  1  consumer accepts head when high with out_valid_o

Behaviour:
- Reset (synchronous, wb_rst_i high at a rising edge): wbs_ack_o=0, wbs_dat_o=0, FIFO pointers and count=0, overflow=0, drop_cnt=0. out_valid_o=0 from the following cycle. Storage contents are don't-care. Reset overrides any simultaneous bus or stream event. An in-flight request is dropped with no ack.
- Request: req = wbs_cyc_i & wbs_stb_i & !wbs_ack_o & (wbs_adr_i==DATA_ADDR | wbs_adr_i==STATUS_ADDR).
- Acknowledge timing:
  - A req sampled at edge N sets wbs_ack_o=1 for exactly the cycle after N.
  - wbs_ack_o is cleared at edge N+1 unconditionally.
  - Back-to-back transfers therefore ack every other cycle.
  - Non-matching addresses are never acked. wbs_dat_o holds its value for those.
- Write DATA_ADDR:
  - At edge N, wbs_dat_i is pushed if count<DEPTH, or if a pop occurs at the same edge.
  - Otherwise the word is dropped. It is still acked. overflow is set to 1, and drop_cnt increments, saturating at 255.
- Write STATUS_ADDR: if wbs_dat_i[0]=1, clear overflow and drop_cnt at edge N. A drop at the same edge loses to the clear. Other bits are ignored. Nothing is pushed.
- Read DATA_ADDR: wbs_dat_o <= head word if count>0, else 32'h0. No pop.
- Read STATUS_ADDR: wbs_dat_o <= {drop_cnt[7:0], 5'b0, overflow, full, empty, count zero-extended to 16 bits}. These values are sampled before edge N's push/pop. Bit fields: [31:24] drop_cnt, [18] overflow, [17] full, [16] empty, [15:0] count.
- Stream side:
  - out_valid_o = (count!=0). out_data_o = mem[rd_ptr]. Both derive from registered state.
  - A pop occurs at an edge where out_valid_o & out_ready_i.
  - A word pushed at edge N appears on out_valid_o/out_data_o in cycle N+1, the same cycle as its ack.
  - out_data_o is stable while out_valid_o=1 and out_ready_i=0.
- Pointers: wr_ptr/rd_ptr are PTR_W bits and wrap modulo DEPTH. count is PTR_W+1 bits, range 0..DEPTH.
- Count update:
  - push only: count+1.
  - pop only: count-1.
  - push and pop at the same edge: count unchanged, both pointers advance.
- Pop when empty and push when full without a pop are impossible by construction.
- wbs_we_i and data are sampled only at the request edge. Dropping cyc/stb while ack is high has no further effect.

Test Plan:
- Reset, then read STATUS_ADDR -> ack one cycle after request; wbs_dat_o=32'h00010000 (empty=1, count=0).
- Write 32'hA5A5_0001 to DATA_ADDR with out_ready_i=0 -> ack pulse; next cycle out_valid_o=1, out_data_o=32'hA5A50001; STATUS read returns 32'h00000001.
- With out_ready_i=0, write 10 words 1..10 to DATA_ADDR (DEPTH=8) -> all 10 acked; STATUS=32'h02060008 (drop_cnt=2, overflow, full, count=8); raising out_ready_i streams 1..8 in order, then out_valid_o=0.
- FIFO full with out_ready_i=1 in the cycle of write 9 -> word 9 accepted, count stays 8, overflow stays 0, word 1 popped.
- Write 32'h1 to STATUS_ADDR after overflow -> drop_cnt=0, overflow=0, count unchanged; write to 32'h30000018 -> no ack ever, FIFO untouched.
- Assert wb_rst_i mid-stream with count=5 and a request pending -> no ack for that request; next cycle out_valid_o=0, STATUS read returns 32'h00010000.
